// File: rtl/sweep_pkg.sv
// Shared types and width helpers for the exhaustive vector sweep checker.
package sweep_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sweep_state_e;

    // Hold counter needs at least one bit even when HOLD is 1.
    function automatic int holdCntWidth(input int hold);
        int w;
        w = $clog2(hold);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sweep_counter.sv
// Hold counter and stimulus vector counter; strobes a compare on the last hold cycle.
module sweep_counter
    import sweep_pkg::*;
#(
    parameter int IN_W = 3,
    parameter int HOLD = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear_i,
    input  logic            enable_i,
    output logic [IN_W-1:0] stim_o,
    output logic            cmp_o,
    output logic            last_o
);

    localparam int HW = holdCntWidth(HOLD);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

    logic [HW-1:0]   hold_q, hold_d;
    logic [IN_W-1:0] stim_q, stim_d;
    logic            holdEnd;

    assign holdEnd = (hold_q == HOLD_LAST);
    assign cmp_o   = enable_i && holdEnd;
    assign last_o  = &stim_q;
    assign stim_o  = stim_q;

    // The vector stays on the last value after the final compare so the FSM can park in DONE.
    always_comb begin
        hold_d = hold_q;
        stim_d = stim_q;
        if (clear_i) begin
            hold_d = '0;
            stim_d = '0;
        end else if (enable_i) begin
            if (holdEnd) begin
                hold_d = '0;
                if (!last_o) begin
                    stim_d = stim_q + 1'b1;
                end
            end else begin
                hold_d = hold_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_q <= '0;
            stim_q <= '0;
        end else begin
            hold_q <= hold_d;
            stim_q <= stim_d;
        end
    end

endmodule

// File: rtl/vector_sweep_checker.sv
// Exhaustive sweep checker: drives every input vector, compares DUT against golden model,
// and reports a saturating mismatch count plus the first failing vector.
module vector_sweep_checker
    import sweep_pkg::*;
#(
    parameter int IN_W  = 3,
    parameter int OUT_W = 2,
    parameter int HOLD  = 10,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [IN_W-1:0]  stim,
    input  logic [OUT_W-1:0] dut_out,
    input  logic [OUT_W-1:0] gold_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [IN_W-1:0]  first_err_vec,
    output logic             first_err_valid
);

    sweep_state_e    state_q, state_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [IN_W-1:0]  fev_q, fev_d;
    logic             fevValid_q, fevValid_d;

    logic startAccepted;
    logic cntClear;
    logic cntEnable;
    logic cmpStrobe;
    logic lastVec;

    // Abort wins over start, so a simultaneous start never re-enters RUN.
    assign startAccepted = start && !abort && (state_q != RUN);
    assign cntClear      = abort || startAccepted;
    assign cntEnable     = (state_q == RUN) && !abort;

    sweep_counter #(
        .IN_W (IN_W),
        .HOLD (HOLD)
    ) u_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (cntClear),
        .enable_i (cntEnable),
        .stim_o   (stim),
        .cmp_o    (cmpStrobe),
        .last_o   (lastVec)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            err_q      <= '0;
            fev_q      <= '0;
            fevValid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            err_q      <= err_d;
            fev_q      <= fev_d;
            fevValid_q <= fevValid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start) state_d = RUN;
                RUN:     if (cmpStrobe && lastVec) state_d = DONE;
                DONE:    if (start) state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    // Error results survive an abort; only a fresh start or reset clears them.
    always_comb begin
        err_d      = err_q;
        fev_d      = fev_q;
        fevValid_d = fevValid_q;
        if (startAccepted) begin
            err_d      = '0;
            fev_d      = '0;
            fevValid_d = 1'b0;
        end else if (cmpStrobe && (dut_out != gold_out)) begin
            if (err_q != {ERR_W{1'b1}}) begin
                err_d = err_q + 1'b1;
            end
            if (!fevValid_q) begin
                fev_d      = stim;
                fevValid_d = 1'b1;
            end
        end
    end

    always_comb begin
        busy            = (state_q == RUN);
        done            = (state_q == DONE);
        pass            = (state_q == DONE) && (err_q == '0);
        err_cnt         = err_q;
        first_err_vec   = fev_q;
        first_err_valid = fevValid_q;
    end

endmodule

// File: tb/tb_vector_sweep_checker.sv
// Directed bench: three checker instances (HOLD=4/ERR_W=4, HOLD=4/ERR_W=2, HOLD=1) against a full-adder golden model.
module tb_vector_sweep_checker;

    logic clk = 1'b0;
    logic rst_n, start, abort;
    int   mode;
    int   vectors = 0;
    int   miscompares = 0;

    logic [2:0] stim0, stim1, stim2;
    logic [1:0] gold0, dut0, gold1, dut1;
    logic [1:0] gold2q = 2'b00;
    logic [1:0] dut2q  = 2'b00;
    logic       busy0, done0, pass0, fevValid0;
    logic       busy1, done1, pass1, fevValid1;
    logic       busy2, done2, pass2, fevValid2;
    logic [3:0] err0, err2;
    logic [1:0] err1;
    logic [2:0] fev0, fev1, fev2;

    always #5 clk = ~clk;

    function automatic logic [1:0] goldOf(input logic [2:0] s);
        return {1'b0, s[0]} + {1'b0, s[1]} + {1'b0, s[2]};
    endfunction

    // mode 0: matching DUT, mode 1: output bit 0 stuck at 0
    assign gold0 = goldOf(stim0);
    assign dut0  = (mode == 0) ? gold0 : {gold0[1], 1'b0};
    assign gold1 = goldOf(stim1);
    assign dut1  = ~gold1;

    always @(posedge clk) begin
        gold2q <= goldOf(stim2);
        dut2q  <= goldOf(stim2);
    end

    vector_sweep_checker #(.IN_W(3), .OUT_W(2), .HOLD(4), .ERR_W(4)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .stim(stim0),
        .dut_out(dut0), .gold_out(gold0), .busy(busy0), .done(done0), .pass(pass0),
        .err_cnt(err0), .first_err_vec(fev0), .first_err_valid(fevValid0)
    );

    vector_sweep_checker #(.IN_W(3), .OUT_W(2), .HOLD(4), .ERR_W(2)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .stim(stim1),
        .dut_out(dut1), .gold_out(gold1), .busy(busy1), .done(done1), .pass(pass1),
        .err_cnt(err1), .first_err_vec(fev1), .first_err_valid(fevValid1)
    );

    vector_sweep_checker #(.IN_W(3), .OUT_W(2), .HOLD(1), .ERR_W(4)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .stim(stim2),
        .dut_out(dut2q), .gold_out(gold2q), .busy(busy2), .done(done2), .pass(pass2),
        .err_cnt(err2), .first_err_vec(fev2), .first_err_valid(fevValid2)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic s, input logic a, input logic r);
        start = s;
        abort = a;
        rst_n = r;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse start for one edge; leaves the bench just after that edge.
    task automatic pulseStart();
        applyStimulus(1'b1, 1'b0, 1'b1);
        tick(1);
        applyStimulus(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        mode = 0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick(2);
        checkOutput("reset_stim", 32'(stim0), 0);
        checkOutput("reset_busy", 32'(busy0), 0);
        checkOutput("reset_done", 32'(done0), 0);
        checkOutput("reset_pass", 32'(pass0), 0);
        checkOutput("reset_err", 32'(err0), 0);
        checkOutput("reset_fev", 32'(fev0), 0);
        checkOutput("reset_fevValid", 32'(fevValid0), 0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        tick(1);

        // Matching DUT: full sweep, stim steps every 4 cycles, done at cycle 32
        pulseStart();
        checkOutput("runA_busy_start", 32'(busy0), 1);
        checkOutput("runA_stim_start", 32'(stim0), 0);
        for (int c = 1; c <= 32; c++) begin
            tick(1);
            if (c < 32 && (c % 4) == 1) checkOutput($sformatf("runA_stim_c%0d", c), 32'(stim0), 32'(c / 4));
            if (c == 7) checkOutput("h1_done_c7", 32'(done2), 0);
            if (c == 8) begin
                checkOutput("h1_done_c8", 32'(done2), 1);
                checkOutput("h1_pass", 32'(pass2), 1);
            end
            if (c == 31) begin
                checkOutput("runA_done_c31", 32'(done0), 0);
                checkOutput("runA_busy_c31", 32'(busy0), 1);
            end
        end
        checkOutput("runA_done", 32'(done0), 1);
        checkOutput("runA_busy", 32'(busy0), 0);
        checkOutput("runA_pass", 32'(pass0), 1);
        checkOutput("runA_err", 32'(err0), 0);
        checkOutput("runA_fevValid", 32'(fevValid0), 0);
        checkOutput("sat_err", 32'(err1), 3);
        checkOutput("sat_pass", 32'(pass1), 0);
        checkOutput("sat_done", 32'(done1), 1);

        // Stuck-at-0 DUT: mismatches on vectors 1,2,4,7; also restarts the HOLD=1 unit from DONE
        mode = 1;
        pulseStart();
        checkOutput("h1_restart_busy", 32'(busy2), 1);
        checkOutput("h1_restart_stim", 32'(stim2), 0);
        tick(32);
        checkOutput("runB_done", 32'(done0), 1);
        checkOutput("runB_err", 32'(err0), 4);
        checkOutput("runB_fev", 32'(fev0), 1);
        checkOutput("runB_fevValid", 32'(fevValid0), 1);
        checkOutput("runB_pass", 32'(pass0), 0);

        // Abort at cycle 10: one error (vector 1) already counted and kept
        pulseStart();
        checkOutput("runC_err_cleared", 32'(err0), 0);
        tick(10);
        applyStimulus(1'b0, 1'b1, 1'b1);
        tick(1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("abort_busy", 32'(busy0), 0);
        checkOutput("abort_done", 32'(done0), 0);
        checkOutput("abort_stim", 32'(stim0), 0);
        checkOutput("abort_err", 32'(err0), 1);
        checkOutput("abort_fevValid", 32'(fevValid0), 1);
        mode = 0;
        pulseStart();
        checkOutput("restart_err", 32'(err0), 0);
        checkOutput("restart_fevValid", 32'(fevValid0), 0);
        tick(31);
        checkOutput("restart_done_c31", 32'(done0), 0);
        tick(1);
        checkOutput("restart_done_c32", 32'(done0), 1);
        checkOutput("restart_pass", 32'(pass0), 1);

        // Abort on the compare edge of mismatching vector 1 discards that compare
        mode = 1;
        pulseStart();
        tick(7);
        applyStimulus(1'b0, 1'b1, 1'b1);
        tick(1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("abortcmp_err", 32'(err0), 0);
        checkOutput("abortcmp_fevValid", 32'(fevValid0), 0);
        checkOutput("abortcmp_busy", 32'(busy0), 0);

        // Reset on the vector-2 compare edge with start high: everything back to reset values
        pulseStart();
        tick(11);
        checkOutput("prereset_err", 32'(err0), 1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick(1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("rst_stim", 32'(stim0), 0);
        checkOutput("rst_busy", 32'(busy0), 0);
        checkOutput("rst_done", 32'(done0), 0);
        checkOutput("rst_err", 32'(err0), 0);
        checkOutput("rst_fev", 32'(fev0), 0);
        checkOutput("rst_fevValid", 32'(fevValid0), 0);
        tick(1);
        checkOutput("rst_idle_busy", 32'(busy0), 0);

        // start during RUN is ignored; sweep still ends at cycle 32
        mode = 0;
        pulseStart();
        tick(5);
        pulseStart();
        tick(25);
        checkOutput("ignstart_done_c31", 32'(done0), 0);
        checkOutput("ignstart_stim_c31", 32'(stim0), 7);
        tick(1);
        checkOutput("ignstart_done_c32", 32'(done0), 1);
        checkOutput("ignstart_pass", 32'(pass0), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
